// File: rtl/bias_stream_ctrl_pkg.sv
// bias_stream_ctrl_pkg: coefficient width, sequencer states and per-layer bias ROM sizes.
package bias_stream_ctrl_pkg;
   localparam int COEFF_WIDTH = 16;
   localparam int CONV1_BIAS_SIZE = 16;
   localparam int CONV2_BIAS_SIZE = 32;
   localparam int CONV3_BIAS_SIZE = 64;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
   function automatic int addr_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/bias_skid_fifo.sv
// bias_skid_fifo: two-entry FIFO that holds ROM words while the downstream port is stalled.
module bias_skid_fifo
   import bias_stream_ctrl_pkg::*;
#(
   parameter int W = COEFF_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count,
   output logic         not_empty
);
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic wr_q, wr_d, rd_q, rd_d;
   logic [1:0] count_q, count_d;
   always_comb begin
      mem_d = mem_q;
      mem_d[wr_q] = push ? din : mem_q[wr_q];
      wr_d = wr_q ^ push;
      rd_d = rd_q ^ pop;
      count_d = count_q + 2'(push) - 2'(pop);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wr_q <= 1'b0;
         rd_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         count_q <= count_d;
      end
   assign head = mem_q[rd_q];
   assign count = count_q;
   assign not_empty = count_q != 2'd0;
endmodule

// File: rtl/bias_stream_ctrl.sv
// bias_stream_ctrl: streams the bias ROM cfg_repeat times into a FIFO port, credit-limited so no word is dropped.
module bias_stream_ctrl
   import bias_stream_ctrl_pkg::*;
#(
   parameter int MEM_SIZE = 16,
   parameter int DATA_WIDTH = COEFF_WIDTH,
   parameter int REPEAT_WIDTH = 16,
   localparam int ADDR_WIDTH = addr_bits(MEM_SIZE)
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    ap_start,
   output logic                    ap_idle,
   output logic                    ap_done,
   input  logic [REPEAT_WIDTH-1:0] cfg_repeat,
   output logic [ADDR_WIDTH-1:0]   bias_address,
   output logic                    bias_ce,
   input  logic [DATA_WIDTH-1:0]   bias_q,
   output logic [DATA_WIDTH-1:0]   output_V_din,
   input  logic                    output_V_full_n,
   output logic                    output_V_write
);
   state_t state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [REPEAT_WIDTH-1:0] pass_q, pass_d, rep_q, rep_d;
   logic inflight_q, inflight_d;
   logic [1:0] count;
   logic not_empty, pop, credit, addr_end, last;
   assign pop = not_empty && output_V_full_n;
   // a read may issue only if the word it returns is guaranteed a free slot
   assign credit = ({1'b0, count} + 3'(inflight_q)) < (3'd2 + 3'(pop));
   assign addr_end = addr_q == ADDR_WIDTH'(MEM_SIZE - 1);
   assign last = addr_end && pass_q == rep_q - REPEAT_WIDTH'(1);
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      pass_d = pass_q;
      rep_d = rep_q;
      bias_ce = 1'b0;
      ap_done = 1'b0;
      case (state_q)
         ST_IDLE: if (ap_start) begin
            rep_d = cfg_repeat;
            addr_d = '0;
            pass_d = '0;
            state_d = (cfg_repeat == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            bias_ce = credit;
            addr_d = credit ? (addr_end ? '0 : addr_q + ADDR_WIDTH'(1)) : addr_q;
            pass_d = (credit && addr_end) ? pass_q + REPEAT_WIDTH'(1) : pass_q;
            state_d = (credit && last) ? ST_DRAIN : ST_RUN;
         end
         ST_DRAIN: state_d = (count == 2'(pop) && !inflight_q) ? ST_DONE : ST_DRAIN;
         default: begin
            ap_done = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end
   assign inflight_d = bias_ce;
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         state_q <= ST_IDLE;
         addr_q <= '0;
         pass_q <= '0;
         rep_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         pass_q <= pass_d;
         rep_q <= rep_d;
         inflight_q <= inflight_d;
      end
   bias_skid_fifo #(.W(DATA_WIDTH)) u_fifo (
      .clk       (ap_clk),
      .rst_n     (ap_rst_n),
      .push      (inflight_q),
      .din       (bias_q),
      .pop       (pop),
      .head      (output_V_din),
      .count     (count),
      .not_empty (not_empty)
   );
   assign ap_idle = state_q == ST_IDLE;
   assign bias_address = addr_q;
   assign output_V_write = pop;
endmodule

// File: tb/tb_bias_stream_ctrl.sv
// tb_bias_stream_ctrl: table-driven and randomized jobs checked against a queue model of the bias stream.
module tb_bias_stream_ctrl;
   localparam int MEM = 4;
   logic ap_clk = 1'b0, ap_rst_n = 1'b0, ap_start = 1'b0;
   logic ap_idle, ap_done, bias_ce, output_V_write;
   logic output_V_full_n = 1'b1;
   logic [15:0] cfg_repeat = '0;
   logic [1:0] bias_address;
   logic [15:0] bias_q = '0;
   logic [15:0] output_V_din;
   logic [15:0] rom [MEM];
   logic [15:0] exp_q [$];
   int checks = 0, errors = 0, cyc = 0;
   int occ = 0;
   bit infl = 1'b0;
   int wr_cnt = 0, ce_cnt = 0, done_cnt = 0, first_wr = 0, last_wr = 0, done_cyc = 0;

   typedef struct {int rep; int mode; bit hold; int exp_writes;} vec_t;
   vec_t vecs [6];

   bias_stream_ctrl #(.MEM_SIZE(MEM), .DATA_WIDTH(16), .REPEAT_WIDTH(16)) dut (
      .ap_clk          (ap_clk),
      .ap_rst_n        (ap_rst_n),
      .ap_start        (ap_start),
      .ap_idle         (ap_idle),
      .ap_done         (ap_done),
      .cfg_repeat      (cfg_repeat),
      .bias_address    (bias_address),
      .bias_ce         (bias_ce),
      .bias_q          (bias_q),
      .output_V_din    (output_V_din),
      .output_V_full_n (output_V_full_n),
      .output_V_write  (output_V_write)
   );

   always #5 ap_clk = ~ap_clk;

   always @(posedge ap_clk) begin
      cyc <= cyc + 1;
      if (bias_ce) bias_q <= rom[bias_address];
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // occ is the buffer occupancy implied by reads issued two cycles back minus words written
   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         occ = 0;
         infl = 1'b0;
      end else begin
         chk("write_rule", output_V_write, occ > 0 && output_V_full_n);
         chk("occupancy_le_2", occ <= 2, 1);
         if (bias_ce) begin
            chk("credit_rule", occ + int'(infl) - int'(output_V_write) < 2, 1);
            ce_cnt++;
         end
         if (output_V_write) begin
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
            chk("write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("din_order", output_V_din, exp_q.pop_front());
         end
         if (ap_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         occ = occ + int'(infl) - int'(output_V_write);
         infl = bias_ce;
      end
   end

   task automatic reset_outputs(input string tag);
      chk({tag, "_idle"}, ap_idle, 1);
      chk({tag, "_done"}, ap_done, 0);
      chk({tag, "_ce"}, bias_ce, 0);
      chk({tag, "_addr"}, bias_address, 0);
      chk({tag, "_write"}, output_V_write, 0);
      chk({tag, "_din"}, output_V_din, 0);
   endtask

   task automatic run_job(input int rep, input int mode, input bit hold, input int exp_writes);
      int s, d0;
      for (int p = 0; p < rep; p++)
         for (int i = 0; i < MEM; i++) exp_q.push_back(rom[i]);
      wr_cnt = 0;
      ce_cnt = 0;
      d0 = done_cnt;
      cfg_repeat = 16'(rep);
      ap_start = 1'b1;
      @(posedge ap_clk); #1;
      s = cyc;
      ap_start = hold;
      for (int k = 0; k < 600 && done_cnt == d0; k++) begin
         output_V_full_n = (mode == 0) ? 1'b1 :
                           (mode == 1) ? !(k >= 3 && k <= 7) :
                           (mode == 2) ? (k % 2 == 0) : ($urandom_range(0, 2) != 0);
         if (hold && k == 5) cfg_repeat = 16'd5;
         @(posedge ap_clk); #1;
      end
      output_V_full_n = 1'b1;
      chk("done_pulses", done_cnt - d0, 1);
      chk("write_count", wr_cnt, exp_writes);
      chk("model_drained", exp_q.size(), 0);
      chk("idle_after_done", ap_idle, 1);
      if (rep == 0) begin
         chk("no_reads", ce_cnt, 0);
         chk("done_latency_rep0", done_cyc - s, 0);
      end else chk("done_after_last_write", done_cyc - last_wr, 1);
      if (mode == 0 && rep > 0) begin
         chk("first_write_latency", first_wr - s, 2);
         chk("back_to_back", last_wr - first_wr, wr_cnt - 1);
      end
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rom = '{16'd10, 16'd11, 16'd12, 16'd13};
      vecs = '{'{2, 0, 1'b0, 8}, '{2, 1, 1'b0, 8}, '{0, 0, 1'b0, 0},
               '{3, 2, 1'b0, 12}, '{2, 0, 1'b1, 8}, '{5, 0, 1'b0, 20}};
      repeat (3) @(posedge ap_clk);
      #1;
      reset_outputs("reset");
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      foreach (vecs[v]) run_job(vecs[v].rep, vecs[v].mode, vecs[v].hold, vecs[v].exp_writes);
      // abort after the fifth word, then a fresh job must restart at address 0
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < MEM; i++) exp_q.push_back(rom[i]);
      wr_cnt = 0;
      cfg_repeat = 16'd2;
      ap_start = 1'b1;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      for (int k = 0; k < 100 && wr_cnt < 5; k++) begin
         @(posedge ap_clk); #1;
      end
      chk("abort_point", wr_cnt, 5);
      ap_rst_n = 1'b0;
      #1;
      reset_outputs("abort");
      exp_q.delete();
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      run_job(1, 0, 1'b0, 4);
      for (int j = 0; j < 8; j++) begin
         int r;
         foreach (rom[i]) rom[i] = 16'($urandom);
         r = $urandom_range(1, 3);
         run_job(r, 3, 1'b0, MEM * r);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
